dm_cache_ctrl: RTL and testbench

- Sequencer that sits between one CPU-side requester, the direct-mapped cache datapath, and the backing RAM.
- Translates CPU read, write and flush requests into cache commands: 00 CLR, 01 CHECK, 10 READ, 11 WRITE.
- Performs dirty write-back and miss fill over a req/ack RAM handshake.
- Controller runs on posedge clk. The cache acts on the negedge in mid-cycle, so each cache command costs exactly one controller cycle.

---
 rtl/dm_cache_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// Sequencer between a CPU requester, a direct-mapped cache datapath and backing RAM.
// Issues one cache command per cycle and runs dirty write-back / miss fill over a req/ack RAM port.
module dm_cache_ctrl #(
    parameter int ramWidth      = 8,
    parameter int addrWidth     = 8,
    parameter int blockAddrBits = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 cpuReq,
    input  logic                 cpuWe,
    input  logic                 cpuFlush,
    input  logic [addrWidth-1:0] cpuAddr,
    input  logic [ramWidth-1:0]  cpuWData,
    output logic [ramWidth-1:0]  cpuRData,
    output logic                 cpuReady,
    output logic                 flushDone,
    output logic                 busy,
    output logic [1:0]           cacheCntrl,
    output logic [addrWidth-1:0] cacheAddr,
    output logic [ramWidth-1:0]  cacheDataIn,
    input  logic [ramWidth-1:0]  cacheDataOut,
    input  logic                 cacheIsHit,
    input  logic                 cacheIsClean,
    input  logic [ramWidth-1:0]  cacheDataOutRAM,
    input  logic [addrWidth-1:0] cacheAddrOutRAM,
    output logic                 ramReq,
    output logic                 ramWe,
    output logic [addrWidth-1:0] ramAddr,
    output logic [ramWidth-1:0]  ramWData,
    input  logic [ramWidth-1:0]  ramRData,
    input  logic                 ramAck
);

    localparam int tagBits = addrWidth - blockAddrBits;

    localparam logic [1:0] CMD_CLR   = 2'b00;
    localparam logic [1:0] CMD_CHECK = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    typedef enum logic [3:0] {
        IDLE, CHECK, WB, FILL, FILLWR, READ, WRITE, DONE, CLR, FDONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [addrWidth-1:0]   r_addrL;
    logic                   r_weL;
    logic [ramWidth-1:0]    r_wdataL;
    logic [addrWidth-1:0]   r_victimAddr;
    logic [ramWidth-1:0]    r_victimData;
    logic [ramWidth-1:0]    r_fillL;
    logic [ramWidth-1:0]    r_cpuRData;
    logic [tagBits-1:0]     w_tag;
    logic [blockAddrBits-1:0] w_index;

    assign w_tag    = r_addrL[addrWidth-1:blockAddrBits];
    assign w_index  = r_addrL[blockAddrBits-1:0];
    assign cpuRData = r_cpuRData;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latches; CPU inputs are don't-care once a request has been accepted.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_addrL      <= '0;
            r_weL        <= 1'b0;
            r_wdataL     <= '0;
            r_victimAddr <= '0;
            r_victimData <= '0;
            r_fillL      <= '0;
            r_cpuRData   <= '0;
        end else begin
            if (r_state == IDLE && !cpuFlush && cpuReq) begin
                r_addrL  <= cpuAddr;
                r_weL    <= cpuWe;
                r_wdataL <= cpuWData;
            end
            if (r_state == CHECK) begin
                r_victimAddr <= cacheAddrOutRAM;
                r_victimData <= cacheDataOutRAM;
            end
            if (r_state == FILL && ramAck) begin
                r_fillL <= ramRData;
            end
            if (r_state == FILLWR) begin
                r_cpuRData <= r_fillL;
            end
            if (r_state == READ) begin
                r_cpuRData <= cacheDataOut;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (cpuFlush)    w_next = CLR;
                else if (cpuReq) w_next = CHECK;
            end
            CHECK: begin
                if (cacheIsHit)        w_next = r_weL ? WRITE : READ;
                else if (!cacheIsClean) w_next = WB;
                else                   w_next = r_weL ? WRITE : FILL;
            end
            WB:      if (ramAck) w_next = r_weL ? WRITE : FILL;
            FILL:    if (ramAck) w_next = FILLWR;
            FILLWR:  w_next = DONE;
            READ:    w_next = DONE;
            WRITE:   w_next = DONE;
            DONE:    w_next = IDLE;
            CLR:     w_next = FDONE;
            FDONE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // READ is the idle command so the cache never clears unless CLR is reached.
    always_comb begin
        cacheCntrl  = CMD_READ;
        cacheAddr   = {w_tag, w_index};
        cacheDataIn = r_wdataL;
        ramReq      = 1'b0;
        ramWe       = 1'b0;
        ramAddr     = '0;
        ramWData    = '0;
        cpuReady    = 1'b0;
        flushDone   = 1'b0;
        busy        = (r_state != IDLE);
        case (r_state)
            CHECK:  cacheCntrl = CMD_CHECK;
            WB: begin
                ramReq   = 1'b1;
                ramWe    = 1'b1;
                ramAddr  = r_victimAddr;
                ramWData = r_victimData;
            end
            FILL: begin
                ramReq  = 1'b1;
                ramAddr = r_addrL;
            end
            FILLWR: begin
                cacheCntrl  = CMD_WRITE;
                cacheDataIn = r_fillL;
            end
            WRITE:  cacheCntrl = CMD_WRITE;
            DONE:   cpuReady   = 1'b1;
            CLR:    cacheCntrl = CMD_CLR;
            FDONE:  flushDone  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with behavioural negedge cache and req/ack RAM models.
// Expected CPU results and RAM transactions are queued at drive time and compared when logged.
`timescale 1ns/1ps
module tb_dm_cache_ctrl;

    logic       clk = 1'b0;
    logic       resetN;
    logic       cpuReq, cpuWe, cpuFlush;
    logic [7:0] cpuAddr, cpuWData, cpuRData;
    logic       cpuReady, flushDone, busy;
    logic [1:0] cacheCntrl;
    logic [7:0] cacheAddr, cacheDataIn;
    logic [7:0] cacheDataOut = 8'h00;
    logic       cacheIsHit = 1'b0;
    logic       cacheIsClean = 1'b1;
    logic [7:0] cacheDataOutRAM = 8'h00;
    logic [7:0] cacheAddrOutRAM = 8'h00;
    logic       ramReq, ramWe, ramAck;
    logic [7:0] ramAddr, ramWData;
    logic [7:0] ramRData = 8'h00;

    always #5 clk = ~clk;

    dm_cache_ctrl #(.ramWidth(8), .addrWidth(8), .blockAddrBits(4)) dut (
        .clk(clk), .resetN(resetN),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuFlush(cpuFlush),
        .cpuAddr(cpuAddr), .cpuWData(cpuWData), .cpuRData(cpuRData),
        .cpuReady(cpuReady), .flushDone(flushDone), .busy(busy),
        .cacheCntrl(cacheCntrl), .cacheAddr(cacheAddr), .cacheDataIn(cacheDataIn),
        .cacheDataOut(cacheDataOut), .cacheIsHit(cacheIsHit), .cacheIsClean(cacheIsClean),
        .cacheDataOutRAM(cacheDataOutRAM), .cacheAddrOutRAM(cacheAddrOutRAM),
        .ramReq(ramReq), .ramWe(ramWe), .ramAddr(ramAddr), .ramWData(ramWData),
        .ramRData(ramRData), .ramAck(ramAck)
    );

    typedef struct packed {logic we; logic [7:0] addr; logic [7:0] data;} ramTxn_t;
    typedef struct packed {logic [7:0] data; logic [7:0] lat;} cpuObs_t;
    typedef struct {string tag; logic isRead; logic [7:0] data; int lat;} cpuExp_t;

    function automatic logic [7:0] ramContent(input logic [7:0] a);
        return a ^ 8'h49;
    endfunction

    // Cache model: one line per index, acts on the falling edge like the real datapath.
    logic [3:0] cTag   [16];
    logic [7:0] cData  [16];
    logic       cDirty [16];
    wire  [3:0] cIdx = cacheAddr[3:0];

    always @(negedge clk) begin
        case (cacheCntrl)
            2'b00: for (int i = 0; i < 16; i++) begin
                cTag[i] <= 4'h0; cData[i] <= 8'h00; cDirty[i] <= 1'b0;
            end
            2'b01: begin
                cacheIsHit      <= (cTag[cIdx] == cacheAddr[7:4]);
                cacheIsClean    <= !cDirty[cIdx];
                cacheAddrOutRAM <= {cTag[cIdx], cIdx};
                cacheDataOutRAM <= cData[cIdx];
            end
            2'b10: cacheDataOut <= cData[cIdx];
            default: begin
                cTag[cIdx]   <= cacheAddr[7:4];
                cData[cIdx]  <= cacheDataIn;
                cDirty[cIdx] <= 1'b1;
            end
        endcase
    end

    // RAM model: acks after ramWait wait cycles; each ack starts a fresh count if ramReq stays high.
    int         ramWait = 0;
    logic       ackModel = 1'b0;
    logic [7:0] ramCnt = 8'h00;
    wire  [7:0] ramPhase = ackModel ? 8'h00 : ramCnt;
    ramTxn_t    ramLog [64];
    int         ramWr = 0;

    assign ramAck = ackModel;

    always @(negedge clk) begin
        if (!ramReq) begin
            ackModel <= 1'b0;
            ramCnt   <= 8'h00;
        end else if (ramPhase == 8'(ramWait)) begin
            ackModel       <= 1'b1;
            ramCnt         <= 8'h00;
            ramRData       <= ramContent(ramAddr);
            ramLog[ramWr]  <= '{ramWe, ramAddr, ramWData};
            ramWr          <= ramWr + 1;
        end else begin
            ackModel <= 1'b0;
            ramCnt   <= ramPhase + 8'h01;
        end
    end

    // Monitor: logs completions with busy-cycle latency and counts flush/RAM activity.
    cpuObs_t cpuLog [64];
    int      cpuWr = 0;
    int      busyCnt = 0, clrCycles = 0, fdPulses = 0, reqCycles = 0;

    always @(negedge clk) begin
        busyCnt <= busy ? busyCnt + 1 : 0;
        if (cacheCntrl == 2'b00) clrCycles <= clrCycles + 1;
        if (flushDone)           fdPulses  <= fdPulses + 1;
        if (ramReq)              reqCycles <= reqCycles + 1;
        if (cpuReady) begin
            cpuLog[cpuWr] <= '{cpuRData, 8'(busyCnt + 1)};
            cpuWr         <= cpuWr + 1;
        end
    end

    int        checks = 0, errors = 0;
    int        cpuRd = 0, ramRd = 0;
    cpuExp_t   expQ[$];
    ramTxn_t   ramExpQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        @(posedge clk); #1;
        cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWData = wdata;
    endtask

    task automatic waitFor(input string tag, input bit forFlush);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (forFlush ? flushDone : cpuReady) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({tag, " completes"}, 32'(seen), 32'd1);
    endtask

    task automatic collectCpu();
        cpuExp_t e;
        cpuObs_t o;
        @(posedge clk); #1;
        e = expQ.pop_front();
        if (cpuRd < cpuWr) begin
            o = cpuLog[cpuRd];
            cpuRd++;
            if (e.isRead) checkOutput({e.tag, " rdata"}, 32'(o.data), 32'(e.data));
            checkOutput({e.tag, " latency"}, 32'(o.lat), 32'(e.lat));
        end else begin
            checkOutput({e.tag, " result logged"}, 32'(cpuWr), 32'(cpuRd + 1));
        end
    endtask

    task automatic checkRam(input string tag);
        ramTxn_t a, x;
        checkOutput({tag, " ram txns"}, 32'(ramWr - ramRd), 32'(ramExpQ.size()));
        while (ramExpQ.size() > 0 && ramRd < ramWr) begin
            x = ramExpQ.pop_front();
            a = ramLog[ramRd];
            ramRd++;
            checkOutput({tag, " ram we"}, 32'(a.we), 32'(x.we));
            checkOutput({tag, " ram addr"}, 32'(a.addr), 32'(x.addr));
            if (x.we) checkOutput({tag, " ram wdata"}, 32'(a.data), 32'(x.data));
        end
        ramExpQ.delete();
        ramRd = ramWr;
    endtask

    task automatic cpuTxn(input string tag, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] expData, input int expLat);
        expQ.push_back('{tag, !we, expData, expLat});
        applyStimulus(we, addr, wdata);
        waitFor(tag, 1'b0);
        cpuReq = 1'b0;
        collectCpu();
        checkRam(tag);
    endtask

    initial begin
        int  clr0, fd0;
        bit  seen, earlyReady;
        resetN = 1'b0; cpuReq = 1'b0; cpuWe = 1'b0; cpuFlush = 1'b0;
        cpuAddr = 8'h00; cpuWData = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset cacheCntrl", 32'(cacheCntrl), 32'h2);
        checkOutput("reset cpuReady", 32'(cpuReady), 32'h0);
        checkOutput("reset flushDone", 32'(flushDone), 32'h0);
        checkOutput("reset ramReq", 32'(ramReq), 32'h0);
        checkOutput("reset ramWe", 32'(ramWe), 32'h0);
        checkOutput("reset cpuRData", 32'(cpuRData), 32'h0);
        checkOutput("reset ramAddr", 32'(ramAddr), 32'h0);
        checkOutput("reset ramWData", 32'(ramWData), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        resetN = 1'b1;

        clr0 = clrCycles; fd0 = fdPulses;
        @(posedge clk); #1;
        cpuFlush = 1'b1;
        waitFor("flush", 1'b1);
        cpuFlush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("flush CLR cycles", 32'(clrCycles - clr0), 32'd1);
        checkOutput("flush pulses", 32'(fdPulses - fd0), 32'd1);

        cpuTxn("write 35 clean miss", 1'b1, 8'h35, 8'hA5, 8'h00, 3);
        cpuTxn("read 35 hit", 1'b0, 8'h35, 8'h00, 8'hA5, 3);
        checkOutput("no ramReq yet", 32'(reqCycles), 32'd0);

        ramWait = 2;
        ramExpQ.push_back('{1'b1, 8'h35, 8'hA5});
        ramExpQ.push_back('{1'b0, 8'h75, 8'h00});
        cpuTxn("read 75 dirty miss", 1'b0, 8'h75, 8'h00, ramContent(8'h75), 9);
        cpuTxn("reread 75 hit", 1'b0, 8'h75, 8'h00, 8'h3C, 3);

        ramWait = 8;
        applyStimulus(1'b0, 8'hB6, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ramReq && !ramWe) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("abort reached FILL", 32'(seen), 32'd1);
        #2;
        resetN = 1'b0; cpuReq = 1'b0;
        #1;
        checkOutput("abort ramReq", 32'(ramReq), 32'h0);
        checkOutput("abort busy", 32'(busy), 32'h0);
        checkOutput("abort cpuReady", 32'(cpuReady), 32'h0);
        checkOutput("abort cacheCntrl", 32'(cacheCntrl), 32'h2);
        checkOutput("abort cpuRData", 32'(cpuRData), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        checkRam("abort");

        ramWait = 1;
        ramExpQ.push_back('{1'b0, 8'hB6, 8'h00});
        cpuTxn("read B6 after reset", 1'b0, 8'hB6, 8'h00, 8'hFF, 5);

        ramWait = 0;
        clr0 = clrCycles; fd0 = fdPulses;
        ramExpQ.push_back('{1'b0, 8'h75, 8'h00});
        expQ.push_back('{"flush+read 75", 1'b1, 8'h3C, 4});
        @(posedge clk); #1;
        cpuFlush = 1'b1; cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 8'h75; cpuWData = 8'h00;
        earlyReady = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cpuReady) earlyReady = 1'b1;
            if (flushDone) begin
                seen = 1'b1;
                break;
            end
        end
        cpuFlush = 1'b0;
        checkOutput("flush+req flushDone", 32'(seen), 32'd1);
        checkOutput("flush+req order", 32'(earlyReady), 32'd0);
        waitFor("flush+req read", 1'b0);
        cpuReq = 1'b0;
        collectCpu();
        checkRam("flush+read 75");
        checkOutput("flush+req CLR cycles", 32'(clrCycles - clr0), 32'd1);
        checkOutput("flush+req pulses", 32'(fdPulses - fd0), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("no stray completions", 32'(cpuWr), 32'(cpuRd));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
